// File: rtl/spi_pkg.sv
// Shared types and ADXL362 constants for the SPI burst controller and its clients.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SCLK_HIGH,
        SCLK_LOW,
        CS_HOLD,
        CS_IDLE
    } spi_state_e;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_FIFO  = 8'h0D;

    localparam logic [7:0] DEVICEID   = 8'h00;
    localparam logic [7:0] PARTID     = 8'h02;
    localparam logic [7:0] STATUS     = 8'h0B;
    localparam logic [7:0] SOFT_RESET = 8'h1F;

endpackage

// File: rtl/spi_half_period_timer.sv
// Reloadable down-counter: pulses tick_o every HALF enabled cycles, parks at reload when disabled.
module spi_half_period_timer #(
    parameter int  HALF = 2,
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [CW-1:0] RELOAD = CW'(HALF - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - CW'(1);
        if (!en_i || tick_o) cnt_d = RELOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= RELOAD;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_burst_cntrl.sv
// SPI mode-0 master, MSB first, running multi-byte bursts under one CS window
// with per-byte tx load / rx deliver handshakes.
module spi_burst_cntrl
    import spi_pkg::*;
#(
    parameter int  CLK_FREQUENCY  = 100_000_000,
    parameter int  SCLK_FREQUENCY = 500_000,
    parameter int  MAX_BYTES      = 16,
    localparam int NB_W           = $clog2(MAX_BYTES + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NB_W-1:0] num_bytes,
    input  logic [7:0]      tx_data,
    output logic            tx_ack,
    output logic [7:0]      rx_data,
    output logic            rx_valid,
    output logic            busy,
    output logic            done,
    output logic            SPI_SCLK,
    output logic            SPI_MOSI,
    output logic            SPI_CS,
    input  logic            SPI_MISO
);

    localparam int HALF = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);

    if (HALF < 2) begin : g_half_chk
        $error("spi_burst_cntrl: HALF must be at least 2");
    end

    spi_state_e      state_q, state_d;
    logic [7:0]      sh_q;
    logic [7:0]      rx_sh_q;
    logic [7:0]      rx_data_q;
    logic [2:0]      bit_q;
    logic [NB_W-1:0] byte_q;
    logic [NB_W-1:0] nb_q;
    logic            idle2_q;
    logic            tx_ack_q, rx_valid_q, done_q;
    logic            tick;
    logic            accept;
    logic            last_byte;

    spi_half_period_timer #(.HALF(HALF)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (state_q != IDLE),
        .tick_o (tick)
    );

    assign accept    = (state_q == IDLE) && start && (num_bytes != '0)
                       && (num_bytes <= NB_W'(MAX_BYTES));
    assign last_byte = (byte_q + NB_W'(1)) == nb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Deselect spans two half periods so a burst lasts HALF*(16*n + 3) cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = CS_SETUP;
            CS_SETUP:  if (tick) state_d = SCLK_HIGH;
            SCLK_HIGH: if (tick) state_d = (bit_q == 3'd7 && last_byte) ? CS_HOLD : SCLK_LOW;
            SCLK_LOW:  if (tick) state_d = SCLK_HIGH;
            CS_HOLD:   if (tick) state_d = CS_IDLE;
            CS_IDLE:   if (tick && idle2_q) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        SPI_CS   = (state_q == IDLE) || (state_q == CS_IDLE);
        SPI_SCLK = (state_q == SCLK_HIGH);
        SPI_MOSI = 1'b0;
        if (state_q == CS_SETUP || state_q == SCLK_HIGH || state_q == SCLK_LOW) SPI_MOSI = sh_q[7];
        busy     = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q       <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            nb_q       <= '0;
            idle2_q    <= 1'b0;
            tx_ack_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_ack_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    sh_q     <= tx_data;
                    tx_ack_q <= 1'b1;
                    nb_q     <= num_bytes;
                    byte_q   <= '0;
                    bit_q    <= '0;
                end
                // MISO is captured on the edge that raises SCLK.
                CS_SETUP, SCLK_LOW: if (tick) rx_sh_q <= {rx_sh_q[6:0], SPI_MISO};
                SCLK_HIGH: if (tick) begin
                    if (bit_q != 3'd7) begin
                        sh_q  <= {sh_q[6:0], 1'b0};
                        bit_q <= bit_q + 3'd1;
                    end else begin
                        rx_data_q  <= rx_sh_q;
                        rx_valid_q <= 1'b1;
                        bit_q      <= '0;
                        byte_q     <= byte_q + NB_W'(1);
                        if (!last_byte) begin
                            sh_q     <= tx_data;
                            tx_ack_q <= 1'b1;
                        end
                    end
                end
                CS_HOLD: idle2_q <= 1'b0;
                CS_IDLE: if (tick) begin
                    if (!idle2_q) idle2_q <= 1'b1;
                    else          done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign tx_ack   = tx_ack_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign done     = done_q;

endmodule

// File: tb/tb_spi_burst_cntrl.sv
// Directed bench for spi_burst_cntrl at HALF=50 with an SPI slave model and bus monitor.
module tb_spi_burst_cntrl;

    localparam int NB_W = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [NB_W-1:0] num_bytes = '0;
    logic [7:0]      tx_data;
    logic            tx_ack, rx_valid, busy, done;
    logic [7:0]      rx_data;
    logic            SPI_SCLK, SPI_MOSI, SPI_CS, SPI_MISO;

    spi_burst_cntrl #(
        .CLK_FREQUENCY  (100_000_000),
        .SCLK_FREQUENCY (1_000_000),
        .MAX_BYTES      (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_bytes(num_bytes),
        .tx_data  (tx_data),
        .tx_ack   (tx_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .done     (done),
        .SPI_SCLK (SPI_SCLK),
        .SPI_MOSI (SPI_MOSI),
        .SPI_CS   (SPI_CS),
        .SPI_MISO (SPI_MISO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor state, written only by the monitor process
    int          ack_cnt = 0, rx_cnt = 0, done_cnt = 0, rises = 0, burst_rises = 0;
    int          cs_falls = 0, cs_rises = 0;
    int          t_csfall = 0, t_csrise = 0, t_rise1 = 0, t_rise2 = 0, t_lastfall = 0, t_done = 0;
    logic [63:0] mosi_cap = '0;
    logic [7:0]  rx_log [0:63];
    logic [7:0]  falls_b = '0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;

    // stimulus tables, written only by the initial block
    logic [7:0]  tx_bytes [0:15];
    logic [7:0]  resp [0:7];
    int          ack_base = 0;

    assign tx_data  = tx_bytes[4'(ack_cnt - ack_base)];
    assign SPI_MISO = resp[falls_b[5:3]][3'd7 - falls_b[2:0]];

    always @(negedge clk) begin
        if (prev_cs && !SPI_CS) begin
            cs_falls    <= cs_falls + 1;
            t_csfall    <= cyc;
            falls_b     <= '0;
            burst_rises <= 0;
        end
        if (!prev_cs && SPI_CS) begin
            cs_rises <= cs_rises + 1;
            t_csrise <= cyc;
        end
        if (!prev_sclk && SPI_SCLK) begin
            rises       <= rises + 1;
            burst_rises <= burst_rises + 1;
            mosi_cap    <= {mosi_cap[62:0], SPI_MOSI};
            if (burst_rises == 0) t_rise1 <= cyc;
            if (burst_rises == 1) t_rise2 <= cyc;
        end
        if (prev_sclk && !SPI_SCLK) begin
            falls_b    <= falls_b + 8'd1;
            t_lastfall <= cyc;
        end
        if (tx_ack) ack_cnt <= ack_cnt + 1;
        if (rx_valid) begin
            rx_log[rx_cnt[5:0]] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            t_done   <= cyc;
        end
        prev_cs   <= SPI_CS;
        prev_sclk <= SPI_SCLK;
    end

    int n_chk = 0, n_pass = 0;
    int s_ack, s_rx, s_rise, s_csf, s_csr, s_done;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic snap();
        s_ack = ack_cnt; s_rx = rx_cnt; s_rise = rises;
        s_csf = cs_falls; s_csr = cs_rises; s_done = done_cnt;
    endtask

    // poke_at > 0 fires an extra start (num_bytes=5) that many cycles into the burst
    task automatic run_burst(input int n, input int poke_at);
        int d0;
        @(posedge clk);
        snap();
        ack_base = ack_cnt;
        d0 = done_cnt;
        @(negedge clk); start = 1'b1; num_bytes = NB_W'(n);
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (poke_at > 0 && i == poke_at) begin
                @(negedge clk); start = 1'b1; num_bytes = 5'd5;
                @(negedge clk); start = 1'b0;
            end
            @(posedge clk);
            if (done_cnt != d0) break;
        end
        repeat (5) @(posedge clk);
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 16; i++) tx_bytes[i] = 8'h00;
        for (int i = 0; i < 8; i++) resp[i] = 8'h00;
    endtask

    initial begin
        clear_tables();

        // reset state
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_cs", SPI_CS, 1);
        chk("rst_sclk", SPI_SCLK, 0);
        chk("rst_mosi", SPI_MOSI, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rxdata", rx_data, 8'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // write burst: 0A 1F 52
        tx_bytes[0] = 8'h0A; tx_bytes[1] = 8'h1F; tx_bytes[2] = 8'h52;
        run_burst(3, 0);
        chk("wr_mosi", mosi_cap[23:0], 24'h0A1F52);
        chk("wr_acks", ack_cnt - s_ack, 3);
        chk("wr_rxv", rx_cnt - s_rx, 3);
        chk("wr_rises", rises - s_rise, 24);
        chk("wr_csfall", cs_falls - s_csf, 1);
        chk("wr_csrise", cs_rises - s_csr, 1);
        chk("wr_done", done_cnt - s_done, 1);
        chk("wr_len", t_done - t_csfall, 50 * (16 * 3 + 3));
        chk("wr_idle_busy", busy, 0);

        // read DEVICEID: slave answers 5A, 00, AD
        clear_tables();
        tx_bytes[0] = 8'h0B; tx_bytes[1] = 8'h00; tx_bytes[2] = 8'h00;
        resp[0] = 8'h5A; resp[1] = 8'h00; resp[2] = 8'hAD;
        run_burst(3, 0);
        chk("rd_rxv", rx_cnt - s_rx, 3);
        chk("rd_byte0", rx_log[s_rx[5:0]], 8'h5A);
        chk("rd_devid", rx_log[6'(s_rx + 2)], 8'hAD);
        chk("rd_rxdata", rx_data, 8'hAD);
        chk("rd_mosi", mosi_cap[23:0], 24'h0B0000);

        // burst read of four data bytes
        clear_tables();
        tx_bytes[0] = 8'h0B;
        resp[2] = 8'hAD; resp[3] = 8'h1D; resp[4] = 8'hF2; resp[5] = 8'h01;
        run_burst(6, 0);
        chk("br_rxv", rx_cnt - s_rx, 6);
        chk("br_acks", ack_cnt - s_ack, 6);
        chk("br_d0", rx_log[6'(s_rx + 2)], 8'hAD);
        chk("br_d1", rx_log[6'(s_rx + 3)], 8'h1D);
        chk("br_d2", rx_log[6'(s_rx + 4)], 8'hF2);
        chk("br_d3", rx_log[6'(s_rx + 5)], 8'h01);
        chk("br_csfall", cs_falls - s_csf, 1);
        chk("br_csrise", cs_rises - s_csr, 1);
        chk("br_rises", rises - s_rise, 48);

        // illegal lengths are ignored
        clear_tables();
        snap();
        @(negedge clk); start = 1'b1; num_bytes = 5'd0;
        @(negedge clk); start = 1'b0;
        repeat (200) @(negedge clk);
        chk("nb0_cs", cs_falls - s_csf, 0);
        chk("nb0_done", done_cnt - s_done, 0);
        chk("nb0_busy", busy, 0);
        @(negedge clk); start = 1'b1; num_bytes = 5'd17;
        @(negedge clk); start = 1'b0;
        repeat (200) @(negedge clk);
        chk("nb17_cs", cs_falls - s_csf, 0);
        chk("nb17_acks", ack_cnt - s_ack, 0);
        chk("nb17_done", done_cnt - s_done, 0);

        // start while busy does not change the burst
        tx_bytes[0] = 8'hA1; tx_bytes[1] = 8'hB2;
        run_burst(2, 400);
        chk("ov_acks", ack_cnt - s_ack, 2);
        chk("ov_rises", rises - s_rise, 16);
        chk("ov_done", done_cnt - s_done, 1);
        chk("ov_mosi", mosi_cap[15:0], 16'hA1B2);
        chk("ov_len", t_done - t_csfall, 50 * (16 * 2 + 3));

        // single-byte timing at HALF=50
        clear_tables();
        tx_bytes[0] = 8'hC3;
        run_burst(1, 0);
        chk("tm_setup", t_rise1 - t_csfall, 50);
        chk("tm_period", t_rise2 - t_rise1, 100);
        chk("tm_hold", t_csrise - t_lastfall, 50);
        chk("tm_total", t_done - t_csfall, 950);
        chk("tm_mosi", mosi_cap[7:0], 8'hC3);

        // reset mid-burst
        tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33; tx_bytes[3] = 8'h44;
        @(posedge clk);
        snap();
        ack_base = ack_cnt;
        @(negedge clk); start = 1'b1; num_bytes = 5'd4;
        @(negedge clk); start = 1'b0;
        repeat (300) @(posedge clk);
        chk("mr_cs_low", SPI_CS, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_cs_now", SPI_CS, 1);
        chk("mr_sclk_now", SPI_SCLK, 0);
        chk("mr_busy_now", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("mr_done", done_cnt - s_done, 0);
        chk("mr_csfall", cs_falls - s_csf, 1);
        chk("mr_rxdata", rx_data, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_burst_cntrl.md
Name: spi_burst_cntrl

Overview:
Parametrised SPI master (mode 0, MSB first) that runs multi-byte bursts under a single chip-select assertion, with per-byte transmit and receive handshakes. It generalises the single-transaction ADXL362 controller so that register bursts and FIFO drains need no extra logic. It sits between the accelerometer/system control FSMs and the SPI pins. The ADXL362 controller becomes a thin client: it sends the command byte, the address byte, then N data bytes.

Parameters:
CLK_FREQUENCY, 100_000_000, system clock in Hz
SCLK_FREQUENCY, 500_000, SPI clock in Hz; HALF = CLK_FREQUENCY/(2*SCLK_FREQUENCY) cycles, elaboration error if HALF < 2
MAX_BYTES, 16, maximum bytes per burst; NB_W = $clog2(MAX_BYTES+1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
num_bytes  in  NB_W  burst length, sampled with start
tx_data  in  8  byte to transmit; byte 0 valid with start, next byte valid before the following load
tx_ack  out  1  one-cycle pulse when tx_data is loaded into the shifter
rx_data  out  8  last received byte
rx_valid  out  1  one-cycle pulse when rx_data updates
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at end of burst
SPI_SCLK  out  1  SPI clock, idles low
SPI_MOSI  out  1  master out
SPI_CS  out  1  chip select, active low, idles high
SPI_MISO  in  1  slave out, sampled on SCLK rising edge

Behaviour:
- Reset (async, rst_n=0): state IDLE; SPI_CS=1, SPI_SCLK=0, SPI_MOSI=0; busy=0, done=0, tx_ack=0, rx_valid=0, rx_data=8'h00; all counters cleared. Reset mid-burst raises CS immediately, with no done pulse.
- Accept: start=1 in IDLE with 1 <= num_bytes <= MAX_BYTES. Otherwise start is ignored: no CS activity, no done. start while busy is ignored.
- Accepted start: same edge loads tx_data into the shifter, pulses tx_ack, latches num_bytes, drives SPI_CS=0, and moves to CS_SETUP.
- CS_SETUP: hold HALF cycles with SCLK=0. MOSI = shifter[7].
- SCLK_HIGH: SCLK=1 for HALF cycles. SPI_MISO is sampled into the rx shifter on the entry edge.
- SCLK_LOW: SCLK=0 for HALF cycles. On entry the shifter shifts left and MOSI is updated.
- Bit counter: after the falling edge of bit 7 of each byte:
  - rx_data takes the assembled byte and rx_valid pulses.
  - If bytes remain, tx_data is loaded, tx_ack pulses, and MOSI = new bit 7 in the same cycle, then SCLK_HIGH follows after HALF.
  - Otherwise go to CS_HOLD.
- CS_HOLD: SCLK=0 for HALF cycles, then SPI_CS=1 → CS_IDLE.
- CS_IDLE: minimum deselect of HALF cycles, then done pulses for one cycle and busy drops on the same edge → IDLE.
- A new start is accepted the cycle after done.
- Burst duration from accepted start to done = HALF*(2 + 16*num_bytes + 1) cycles ±1.
- Exactly num_bytes tx_ack pulses and exactly num_bytes rx_valid pulses per burst.
- tx_data must stay stable from one tx_ack until the client updates it. The client has at least 15*HALF cycles to present the next byte.
- Counters: half-period counter $clog2(HALF) bits, bit counter 3 bits, byte counter NB_W bits, with no wrap beyond num_bytes.

Decomposition:
- Shared package spi_pkg:
  - state enum (IDLE, CS_SETUP, SCLK_HIGH, SCLK_LOW, CS_HOLD, CS_IDLE)
  - ADXL362 command constants: CMD_WRITE=8'h0A, CMD_READ=8'h0B, CMD_FIFO=8'h0D
  - register addresses: DEVICEID=8'h00, PARTID=8'h02, STATUS=8'h0B, SOFT_RESET=8'h1F
- One sub-module, spi_half_period_timer: reloadable down-counter that pulses `tick` every HALF cycles while enabled, cleared on rst_n.

Test Plan:
- Reset with CS/SCLK idle: hold rst_n=0 for 5 cycles → SPI_CS=1, SPI_SCLK=0, busy=0, done=0. Assert rst_n=0 mid-burst → SPI_CS=1 within the same cycle, no done pulse.
- Write burst: num_bytes=3, tx 0x0A,0x1F,0x52 → MOSI captured on SCLK rises equals 0x0A1F52, 3 tx_ack, 24 SCLK rising edges, one CS-low window, done once.
- Read DEVICEID: num_bytes=3, tx 0x0B,0x00,0x00, slave model returns 0xAD on byte 2 → third rx_valid shows rx_data=0xAD.
- Burst read: tx 0x0B,0x00 + 4 dummies, slave returns 0xAD,0x1D,0xF2,0x01 → rx_valid pulses 3-6 show those values in order, CS low throughout.
- Illegal and overlapping start: start with num_bytes=0 → no CS edge, no done. start with num_bytes=MAX_BYTES+1 → ignored. start while busy → burst length unchanged.
- Timing check at SCLK_FREQUENCY=1_000_000 (HALF=50): CS fall to first SCLK rise = 50 cycles, SCLK period = 100 cycles, last fall to CS rise = 50 cycles, num_bytes=1 duration = 950±1 cycles.
